// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard / forwarding controller.
package hazard_pkg;

  localparam int unsigned REG_ADDR_W = 5;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // Producer metadata carried down the shadow pipeline.
  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  regwrite;
  } dest_t;

  // The EX entry also needs its sources and the load flag for hazard checks.
  typedef struct packed {
    dest_t                 dst;
    logic                  memread;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
  } ex_t;

endpackage

// File: rtl/hazard_forward_ctrl_fwd_select.sv
// Per-operand forwarding comparator: youngest matching producer wins, x0 never forwards.
module fwd_select
  import hazard_pkg::*;
(
  input  dest_t                 mem_ent,
  input  dest_t                 wb_ent,
  input  logic [REG_ADDR_W-1:0] src,
  output logic [1:0]            sel
);

  always_comb begin
    sel = FWD_REG;
    if (mem_ent.valid && mem_ent.regwrite && (mem_ent.rd != '0) && (mem_ent.rd == src))
      sel = FWD_MEM;
    else if (wb_ent.valid && wb_ent.regwrite && (wb_ent.rd != '0) && (wb_ent.rd == src))
      sel = FWD_WB;
  end

endmodule

// File: rtl/hazard_forward_ctrl.sv
// Hazard controller: shadow EX/MEM/WB metadata, operand forwarding selects,
// load-use / branch / memory-busy stall and flush generation, saturating event counters.
module hazard_forward_ctrl #(
  parameter int unsigned REG_ADDR_W = hazard_pkg::REG_ADDR_W,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_regwrite,
  input  logic                  id_memread,
  input  logic                  branch_taken,
  input  logic                  mem_busy,
  output logic [1:0]            forward_a,
  output logic [1:0]            forward_b,
  output logic                  stall_if,
  output logic                  stall_id,
  output logic                  freeze,
  output logic                  flush_id,
  output logic                  flush_ex,
  output logic [CNT_W-1:0]      stall_count,
  output logic [CNT_W-1:0]      flush_count
);
  import hazard_pkg::*;

  ex_t   ex_q;
  dest_t mem_q;
  dest_t wb_q;
  ex_t   id_ent;
  logic  load_use;

  always_comb begin
    id_ent              = '0;
    id_ent.dst.valid    = id_valid;
    id_ent.dst.rd       = id_rd;
    id_ent.dst.regwrite = id_regwrite;
    id_ent.memread      = id_memread;
    id_ent.rs1          = id_rs1;
    id_ent.rs2          = id_rs2;
  end

  assign load_use = ex_q.dst.valid && ex_q.memread && (ex_q.dst.rd != '0) && id_valid &&
                    ((ex_q.dst.rd == id_rs1) || (ex_q.dst.rd == id_rs2));

  // Priority: memory busy freezes everything, then a taken branch, then load-use.
  always_comb begin
    freeze   = mem_busy;
    stall_if = 1'b0;
    stall_id = 1'b0;
    flush_id = 1'b0;
    flush_ex = 1'b0;
    if (mem_busy) begin
      stall_if = 1'b1;
      stall_id = 1'b1;
    end else if (branch_taken) begin
      flush_id = 1'b1;
      flush_ex = 1'b1;
    end else if (load_use) begin
      stall_if = 1'b1;
      stall_id = 1'b1;
      flush_ex = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (!freeze) begin
        wb_q  <= mem_q;
        mem_q <= ex_q.dst;
        ex_q  <= flush_ex ? '0 : id_ent;
      end
      if (stall_if && (stall_count != '1))
        stall_count <= stall_count + CNT_W'(1);
      if (flush_id && (flush_count != '1))
        flush_count <= flush_count + CNT_W'(1);
    end
  end

  fwd_select u_fwd_a (
    .mem_ent (mem_q),
    .wb_ent  (wb_q),
    .src     (ex_q.rs1),
    .sel     (forward_a)
  );

  fwd_select u_fwd_b (
    .mem_ent (mem_q),
    .wb_ent  (wb_q),
    .src     (ex_q.rs2),
    .sel     (forward_b)
  );

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Self-checking bench for hazard_forward_ctrl: directed scenarios plus randomized traffic
// against a behavioural pipeline model.
module tb_hazard_forward_ctrl;
  localparam int CW   = 6;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          id_valid;
  logic [4:0]    id_rs1, id_rs2, id_rd;
  logic          id_regwrite, id_memread, branch_taken, mem_busy;
  logic [1:0]    forward_a, forward_b;
  logic          stall_if, stall_id, freeze, flush_id, flush_ex;
  logic [CW-1:0] stall_count, flush_count;

  hazard_forward_ctrl #(.REG_ADDR_W(5), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread),
    .branch_taken(branch_taken), .mem_busy(mem_busy), .forward_a(forward_a),
    .forward_b(forward_b), .stall_if(stall_if), .stall_id(stall_id), .freeze(freeze),
    .flush_id(flush_id), .flush_ex(flush_ex), .stall_count(stall_count),
    .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  int ntests = 0;
  int nfail  = 0;

  typedef struct {
    bit v;
    int rd, rs1, rs2;
    bit rw, mr;
  } ent_t;

  ent_t pipe[3];  // 0 = EX, 1 = MEM, 2 = WB
  int   m_stalls, m_flushes, m_fa, m_fb;
  bit   m_freeze, m_stall, m_fid, m_fex;

  function automatic int fwd_of(int src);
    for (int s = 1; s <= 2; s++)
      if (pipe[s].v && pipe[s].rw && pipe[s].rd != 0 && pipe[s].rd == src)
        return (s == 1) ? 2 : 1;
    return 0;
  endfunction

  task automatic model_clear();
    for (int s = 0; s < 3; s++) pipe[s] = '{default: 0};
    m_stalls  = 0;
    m_flushes = 0;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ntests++;
    assert (got === exp)
    else begin
      nfail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic model_out();
    bit lu;
    lu = pipe[0].v && pipe[0].mr && pipe[0].rd != 0 && id_valid &&
         (pipe[0].rd == int'(id_rs1) || pipe[0].rd == int'(id_rs2));
    m_freeze = mem_busy;
    m_stall  = mem_busy || (!branch_taken && lu);
    m_fid    = !mem_busy && branch_taken;
    m_fex    = !mem_busy && (branch_taken || lu);
    m_fa     = fwd_of(pipe[0].rs1);
    m_fb     = fwd_of(pipe[0].rs2);
  endtask

  task automatic half();
    @(negedge clk);
    model_out();
    chk("forward_a", forward_a, m_fa);
    chk("forward_b", forward_b, m_fb);
    chk("stall_if", stall_if, m_stall);
    chk("stall_id", stall_id, m_stall);
    chk("freeze", freeze, m_freeze);
    chk("flush_id", flush_id, m_fid);
    chk("flush_ex", flush_ex, m_fex);
    chk("stall_count", stall_count, m_stalls);
    chk("flush_count", flush_count, m_flushes);
  endtask

  task automatic adv();
    @(posedge clk);
    if (reset) model_clear();
    else begin
      if (m_stall) m_stalls = (m_stalls < CMAX) ? m_stalls + 1 : CMAX;
      if (m_fid) m_flushes = (m_flushes < CMAX) ? m_flushes + 1 : CMAX;
      if (!m_freeze) begin
        pipe[2] = pipe[1];
        pipe[1] = pipe[0];
        if (m_fex) pipe[0] = '{default: 0};
        else pipe[0] = '{v: id_valid, rd: int'(id_rd), rs1: int'(id_rs1), rs2: int'(id_rs2),
                         rw: id_regwrite, mr: id_memread};
      end
    end
    #1;
  endtask

  task automatic drive(input bit v, input int rs1, input int rs2, input int rd,
                       input bit rw, input bit mr, input bit br, input bit busy);
    id_valid     = v;
    id_rs1       = 5'(rs1);
    id_rs2       = 5'(rs2);
    id_rd        = 5'(rd);
    id_regwrite  = rw;
    id_memread   = mr;
    branch_taken = br;
    mem_busy     = busy;
  endtask

  task automatic idle(input bit busy);
    drive(0, 0, 0, 0, 0, 0, 0, busy);
  endtask

  task automatic step(input bit v, input int rs1, input int rs2, input int rd,
                      input bit rw, input bit mr);
    drive(v, rs1, rs2, rd, rw, mr, 0, 0);
    half();
    adv();
  endtask

  bit prev_stall, prev_fid, hold_br;

  initial begin
    reset = 1'b1;
    idle(0);
    repeat (2) @(posedge clk);
    #1;
    model_clear();
    reset = 1'b0;

    // Idle after reset
    repeat (3) begin
      idle(0);
      half();
      chk("t1_fwd_a", forward_a, 0);
      chk("t1_stall_if", stall_if, 0);
      chk("t1_stall_count", stall_count, 0);
      adv();
    end

    // Back-to-back dependency forwards from MEM
    step(1, 1, 2, 5, 1, 0);
    step(1, 5, 1, 6, 1, 0);
    idle(0); half();
    chk("t2_mem_fwd_a", forward_a, 2);
    chk("t2_mem_fwd_b", forward_b, 0);
    adv();
    // One instruction gap forwards from WB
    step(1, 1, 2, 5, 1, 0);
    step(1, 1, 2, 9, 1, 0);
    step(1, 5, 1, 6, 1, 0);
    idle(0); half();
    chk("t2_wb_fwd_a", forward_a, 1);
    adv();

    // Load-use: one stall cycle, then WB forwarding on both operands
    step(1, 2, 0, 7, 1, 1);
    drive(1, 7, 7, 8, 1, 0, 0, 0); half();
    chk("t3_stall_if", stall_if, 1);
    chk("t3_stall_id", stall_id, 1);
    chk("t3_flush_ex", flush_ex, 1);
    adv();
    half();
    chk("t3_no_2nd_stall", stall_if, 0);
    adv();
    idle(0); half();
    chk("t3_fwd_a", forward_a, 1);
    chk("t3_fwd_b", forward_b, 1);
    chk("t3_stall_count", stall_count, 1);
    adv();

    // Taken branch suppresses a pending load-use
    step(1, 2, 0, 7, 1, 1);
    drive(1, 7, 7, 8, 1, 0, 1, 0); half();
    chk("t4_flush_id", flush_id, 1);
    chk("t4_flush_ex", flush_ex, 1);
    chk("t4_stall_if", stall_if, 0);
    adv();
    idle(0); half();
    chk("t4_flush_id_off", flush_id, 0);
    chk("t4_flush_count", flush_count, 1);
    adv();

    // Memory busy for 4 cycles holds the forwarding match
    step(1, 1, 2, 5, 1, 0);
    step(1, 5, 1, 6, 1, 0);
    repeat (4) begin
      idle(1); half();
      chk("t5_freeze", freeze, 1);
      chk("t5_stall_if", stall_if, 1);
      chk("t5_fwd_a", forward_a, 2);
      adv();
    end
    idle(0); half();
    chk("t5_stall_count", stall_count, 5);
    adv();

    // Reset on the 3rd busy cycle clears everything
    step(1, 1, 2, 5, 1, 0);
    step(1, 5, 1, 6, 1, 0);
    repeat (2) begin idle(1); half(); adv(); end
    idle(1); reset = 1'b1; half(); adv();
    reset = 1'b0;
    idle(0); half();
    chk("t5r_fwd_a", forward_a, 0);
    chk("t5r_stall_if", stall_if, 0);
    chk("t5r_freeze", freeze, 0);
    chk("t5r_stall_count", stall_count, 0);
    chk("t5r_flush_count", flush_count, 0);
    adv();

    // Writes to x0 never forward
    step(1, 1, 2, 0, 1, 0);
    step(1, 1, 2, 0, 1, 0);
    step(1, 0, 0, 3, 1, 0);
    idle(0); half();
    chk("t6_x0_fwd_a", forward_a, 0);
    chk("t6_x0_fwd_b", forward_b, 0);
    adv();

    // Stall counter saturates
    repeat (CMAX + 7) begin idle(1); half(); adv(); end
    idle(0); half();
    chk("t6_stall_sat", stall_count, CMAX);
    adv();

    // Randomized traffic on a small register set to provoke many hazards
    prev_stall = 0; prev_fid = 0; hold_br = 0;
    for (int i = 0; i < 3000; i++) begin
      if (prev_fid) begin
        id_valid = 1'b0;
        id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3));
        id_rd = 5'($urandom_range(0, 3));
        id_regwrite = 1'($urandom); id_memread = 1'($urandom);
      end else if (!prev_stall) begin
        id_valid = ($urandom_range(0, 7) != 0);
        id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3));
        id_rd = 5'($urandom_range(0, 3));
        id_regwrite = ($urandom_range(0, 3) != 0);
        id_memread = ($urandom_range(0, 2) == 0);
      end
      branch_taken = hold_br ? 1'b1 : ($urandom_range(0, 9) == 0);
      mem_busy = ($urandom_range(0, 5) == 0);
      reset = ($urandom_range(0, 199) == 0);
      half();
      prev_stall = m_stall && !reset;
      prev_fid = m_fid && !reset;
      hold_br = branch_taken && mem_busy && !reset;
      adv();
    end
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
